sipo_deserializer: RTL and testbench

Serial-to-parallel receiver: collects a 1-bit stream into N-bit words and presents each word on a valid/ready parallel port.
It is the receive-side counterpart to the team's parallel-load/shift register used as a transmitter.
It sits between a serial link front-end and word-wide datapath logic.
It supports MSB-first or LSB-first bit order, frame resynchronisation, and reports overrun and framing errors.

---
 rtl/shift_reg_pkg.sv | 27 ++
 rtl/sipo_deserializer.sv | 146 ++++++++++++++
 tb/tb_sipo_deserializer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_pkg
// Description : Shared types and opcodes for the shift-register family
//               (parallel-load transmitter, serial-to-parallel receiver).
// Revision    : 1.0 - initial release
// ============================================================================
package shift_reg_pkg;

    // Order in which bits travel on the serial wire.
    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } bit_order_e;

    // Per-cycle operation applied to a shift register of the family.
    //   HOLD  : keep contents
    //   SHIFT : move one serial bit in
    //   LOAD  : begin a new word (the bit enters a cleared register)
    //   CLEAR : zero the register
    localparam logic [1:0] c_OP_HOLD  = 2'd0;
    localparam logic [1:0] c_OP_SHIFT = 2'd1;
    localparam logic [1:0] c_OP_LOAD  = 2'd2;
    localparam logic [1:0] c_OP_CLEAR = 2'd3;

endpackage : shift_reg_pkg
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer
// Description : Collects a 1-bit serial stream into N-bit words and offers
//               each completed word on a valid/ready parallel port. Supports
//               MSB/LSB-first order, resync via ser_first, sticky overrun and
//               framing-error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer
    import shift_reg_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 msb_first,
    input  logic                 ser_valid,
    input  logic                 ser_data,
    input  logic                 ser_first,
    output logic [N-1:0]         par_data,
    output logic                 par_valid,
    input  logic                 par_ready,
    output logic [$clog2(N)-1:0] bit_cnt,
    output logic                 overrun,
    output logic                 frame_err
);

    localparam int c_CW = $clog2(N);

    // A one-bit word cannot be deserialised; stop elaboration.
    if (N < 2) begin : g_bad_width
        $fatal(1, "sipo_deserializer: N must be >= 2");
    end

    logic [N-1:0]    r_asm;
    logic [N-1:0]    r_par_data;
    logic            r_par_valid;
    logic [c_CW-1:0] r_bit_cnt;
    logic            r_overrun;
    logic            r_frame_err;
    bit_order_e      r_order;

    logic            w_start;
    logic            w_last;
    logic            w_consume;
    logic            w_resync_err;
    bit_order_e      w_order;
    logic [1:0]      w_op;
    logic [N-1:0]    w_base;
    logic [N-1:0]    w_shifted;

    // A bit starts a new word either at a word boundary or when ser_first
    // forces resynchronisation; that is also where the bit order is latched.
    assign w_start      = ser_valid && (ser_first || (r_bit_cnt == '0));
    assign w_resync_err = ser_valid && ser_first && (r_bit_cnt != '0);
    // ser_first always makes the current bit bit 0, so it can never complete.
    assign w_last       = ser_valid && !ser_first && (r_bit_cnt == c_CW'(N - 1));
    assign w_consume    = r_par_valid && par_ready;
    assign w_order      = w_start ? bit_order_e'(msb_first) : r_order;

    // Select the assembly-register operation for this cycle.
    always_comb begin
        w_op = c_OP_HOLD;
        if (clear) begin
            w_op = c_OP_CLEAR;
        end else if (w_start) begin
            w_op = c_OP_LOAD;
        end else if (ser_valid) begin
            w_op = c_OP_SHIFT;
        end
    end

    // Starting from a cleared base discards any partial word on resync.
    assign w_base    = (w_op == c_OP_LOAD) ? '0 : r_asm;
    assign w_shifted = (w_order == MSB_FIRST) ? {w_base[N-2:0], ser_data}
                                              : {ser_data, w_base[N-1:1]};

    // Assembly shift register, bit counter and bit-order lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm     <= '0;
            r_bit_cnt <= '0;
            r_order   <= LSB_FIRST;
        end else begin
            case (w_op)
                c_OP_CLEAR: begin
                    r_asm     <= '0;
                    r_bit_cnt <= '0;
                    r_order   <= LSB_FIRST;
                end
                c_OP_LOAD: begin
                    r_asm     <= w_shifted;
                    r_bit_cnt <= c_CW'(1);
                    r_order   <= w_order;
                end
                c_OP_SHIFT: begin
                    r_asm     <= w_shifted;
                    r_bit_cnt <= w_last ? '0 : r_bit_cnt + c_CW'(1);
                end
                default: begin
                    r_asm     <= r_asm;
                end
            endcase
        end
    end

    // Holding register with valid/ready handshake and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_data  <= '0;
            r_par_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (clear) begin
            r_par_data  <= '0;
            r_par_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_resync_err) begin
                r_frame_err <= 1'b1;
            end
            if (w_last) begin
                // Holding slot free now (or freed by this handshake): take word.
                if (!r_par_valid || par_ready) begin
                    r_par_data  <= w_shifted;
                    r_par_valid <= 1'b1;
                end else begin
                    r_overrun   <= 1'b1;
                end
            end else if (w_consume) begin
                r_par_valid <= 1'b0;
            end
        end
    end

    assign par_data  = r_par_data;
    assign par_valid = r_par_valid;
    assign bit_cnt   = r_bit_cnt;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule : sipo_deserializer
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deserializer
// Description : Self-checking bench for sipo_deserializer (N=8): directed
//               scenarios followed by random traffic against a word-level
//               reference model built from bit queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;

    localparam int N  = 8;
    localparam int CW = $clog2(N);

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          msb_first;
    logic          ser_valid;
    logic          ser_data;
    logic          ser_first;
    logic [N-1:0]  par_data;
    logic          par_valid;
    logic          par_ready;
    logic [CW-1:0] bit_cnt;
    logic          overrun;
    logic          frame_err;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state: bits of the word in arrival order.
    logic         m_bits[$];
    logic         m_order;
    logic         m_valid;
    logic [N-1:0] m_data;
    logic         m_ovr;
    logic         m_ferr;

    sipo_deserializer #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .msb_first (msb_first),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_first (ser_first),
        .par_data  (par_data),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .bit_cnt   (bit_cnt),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_order = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
    endtask

    // Word value from bits in arrival order: first bit is the MSB or LSB.
    function automatic logic [N-1:0] compose(input logic msb);
        logic [N-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            if (m_bits[i]) begin
                if (msb) w = w | (N'(1) << (N - 1 - i));
                else     w = w | (N'(1) << i);
            end
        end
        return w;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".par_valid"}, 32'(par_valid), 32'(m_valid));
        chk({tag, ".par_data"},  32'(par_data),  32'(m_data));
        chk({tag, ".bit_cnt"},   32'(bit_cnt),   32'(m_bits.size()));
        chk({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic cycle(input logic v, input logic d, input logic f,
                         input logic m, input logic r, input logic clr,
                         input string tag);
        logic         complete;
        logic [N-1:0] word;
        clear     = clr;
        ser_valid = v;
        ser_data  = d;
        ser_first = f;
        msb_first = m;
        par_ready = r;
        complete  = 1'b0;
        word      = '0;
        if (clr) begin
            model_reset();
        end else begin
            if (v) begin
                if (f && m_bits.size() != 0) m_ferr = 1'b1;
                if (f || m_bits.size() == 0) begin
                    m_bits.delete();
                    m_order = m;
                end
                m_bits.push_back(d);
                if (m_bits.size() == N) begin
                    word     = compose(m_order);
                    complete = 1'b1;
                    m_bits.delete();
                end
            end
            if (complete) begin
                if (!m_valid || r) begin
                    m_data  = word;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && r) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Send seq[N-1] first; optionally invert msb_first from bit index tog on.
    task automatic send_seq(input logic [N-1:0] seq, input logic msb,
                            input logic r_early, input logic r_last,
                            input int tog, input string tag);
        for (int k = 0; k < N; k++) begin
            logic mm;
            mm = (tog >= 0 && k >= tog) ? ~msb : msb;
            cycle(1'b1, seq[N-1-k], 1'b0, mm, (k == N - 1) ? r_last : r_early, 1'b0, tag);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        msb_first = 1'b0;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        ser_first = 1'b0;
        par_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // 1: MSB-first 1,1,0,0,0,0,0,0 -> C0, then handshake drains it
        send_seq(8'b1100_0000, 1'b1, 1'b1, 1'b1, -1, "t1");
        chk("t1.data_c0", 32'(par_data), 32'h0000_00C0);
        chk("t1.valid_up", 32'(par_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "t1_drain");
        chk("t1.valid_down", 32'(par_valid), 32'd0);

        // 2: LSB-first same bits -> 03; again with msb_first flipped after bit 3
        send_seq(8'b1100_0000, 1'b0, 1'b1, 1'b1, -1, "t2a");
        chk("t2a.data_03", 32'(par_data), 32'h0000_0003);
        send_seq(8'b1100_0000, 1'b0, 1'b1, 1'b1, 3, "t2b");
        chk("t2b.data_03", 32'(par_data), 32'h0000_0003);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t2_drain");

        // 3: overrun while holding 3C
        send_seq(8'h3C, 1'b1, 1'b0, 1'b0, -1, "t3a");
        send_seq(8'h81, 1'b1, 1'b0, 1'b0, -1, "t3b");
        chk("t3.data_3c", 32'(par_data), 32'h0000_003C);
        chk("t3.overrun", 32'(overrun), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "t3_drain");
        chk("t3.valid_down", 32'(par_valid), 32'd0);
        chk("t3.overrun_sticky", 32'(overrun), 32'd1);

        // 4: clear, then back-to-back replacement in the consuming cycle
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "t4_clear");
        chk("t4.clear_ovr", 32'(overrun), 32'd0);
        send_seq(8'hA5, 1'b1, 1'b0, 1'b0, -1, "t4a");
        send_seq(8'h5A, 1'b1, 1'b0, 1'b1, -1, "t4b");
        chk("t4.data_5a", 32'(par_data), 32'h0000_005A);
        chk("t4.valid_kept", 32'(par_valid), 32'd1);
        chk("t4.no_overrun", 32'(overrun), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "t4_drain");

        // 5: resync with ser_first after 3 bits
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "t5_p0");
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "t5_p1");
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "t5_p2");
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "t5_first");
        chk("t5.frame_err", 32'(frame_err), 32'd1);
        chk("t5.bit_cnt_1", 32'(bit_cnt), 32'd1);
        for (int k = 6; k >= 0; k--) begin
            logic [N-1:0] f0;
            f0 = 8'hF0;
            cycle(1'b1, f0[k], 1'b0, 1'b1, 1'b1, 1'b0, "t5_rest");
        end
        chk("t5.data_f0", 32'(par_data), 32'h0000_00F0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "t5_drain");

        // 6: asynchronous reset mid-word, then a fresh word
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "t6_partial");
        end
        ser_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_seq(8'h96, 1'b1, 1'b1, 1'b1, -1, "t6b");
        chk("t6.data_96", 32'(par_data), 32'h0000_0096);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 63) == 0),
                  "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_sipo_deserializer
`default_nettype wire
